mef_tanques: RTL and testbench
==============================

MEF_TANQUES -- requirements
Module: mef_tanques

Interface
REQ-001 Parameter N_CH, default 4: number of independent tank channels (1..8).
REQ-002 Parameter TW, default 8: timer width in bits.
REQ-003 Parameter T_FILL_MAX, default 200: fill timeout in cycles.
REQ-004 Parameter T_PROC, default 50: process (hold) duration in cycles.
REQ-005 Parameter T_DRAIN_MAX, default 200: drain timeout in cycles.
REQ-006 clock  in  1  single system clock, rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  global run enable, level-sensitive.
REQ-009 nivel_alto  in  N_CH  per-channel tank-full sensor.
REQ-010 nivel_baixo  in  N_CH  per-channel tank-empty sensor.
REQ-011 ack_alarme  in  N_CH  per-channel alarm acknowledge.
REQ-012 ev  out  N_CH  per-channel inlet valve.
REQ-013 ve  out  N_CH  per-channel outlet valve.
REQ-014 motor  out  1  shared drain pump.
REQ-015 alarme  out  N_CH  per-channel alarm.
REQ-016 estado  out  3*N_CH  per-channel state code, channel i at bits [3i+2:3i].

Function
REQ-017 Each channel SHALL run its own FSM: IDLE=0, FILL=1, PROC=2, WAIT=3, DRAIN=4, ALARM=5.
REQ-018 Each channel SHALL have a TW-bit timer cleared on every state entry and incremented each cycle otherwise, saturating at all-ones.
REQ-019 IDLE -> FILL when start=1.
REQ-020 FILL: ev=1; -> PROC on nivel_alto=1; -> ALARM when timer = T_FILL_MAX-1 without nivel_alto; -> WAIT on start=0.
REQ-021 PROC: all channel outputs 0; -> WAIT when timer = T_PROC-1 or start=0.
REQ-022 WAIT: outputs 0; -> DRAIN on the cycle after grant from the arbiter.
REQ-023 DRAIN: ve=1; -> IDLE on nivel_baixo=1; -> ALARM when timer = T_DRAIN_MAX-1 without nivel_baixo.
REQ-024 ALARM: alarme=1, ev=ve=0; -> IDLE on ack_alarme=1 only.
REQ-025 In FILL, PROC, WAIT or DRAIN, nivel_alto=1 and nivel_baixo=1 together SHALL force -> ALARM (sensor fault), with priority over all other transitions.
REQ-026 Timeout and sensor completion in the same cycle: sensor completion wins.
REQ-027 Arbiter SHALL grant at most one channel, only when no channel is in DRAIN; motor = OR of all ve.
REQ-028 Arbiter SHALL be round-robin: the lowest-index WAIT channel at or after pointer wins; pointer := winner+1 modulo N_CH.
REQ-029 Outputs SHALL be Moore (registered state decode only); ev and ve never both 1 on one channel.

Reset
REQ-030 reset_n=0 SHALL asynchronously force all channels to IDLE, timers to 0, arbiter pointer to 0, and all outputs to 0.
REQ-031 Reset mid-DRAIN or mid-FILL SHALL close valves immediately, without waiting for a clock edge.

Structure
REQ-032 State codes and default timer constants SHALL reside in shared package mef_tanques_pkg.
REQ-033 Per-channel FSM plus timer SHALL be sub-module mef_canal, instantiated N_CH times; arbiter and motor OR stay in top.

Verification (N_CH=4, T_FILL_MAX=10, T_PROC=5, T_DRAIN_MAX=10)
REQ-034 start=1, nivel_alto[0] at cycle 4, nivel_baixo[0] 3 cycles into DRAIN -> ch0 IDLE,FILL,PROC(5 cycles),WAIT,DRAIN,IDLE; ev0 high 4 cycles.
REQ-035 start=1, nivel_alto held 0 -> ch0 enters ALARM after 10 FILL cycles; alarme[0]=1 until ack_alarme[0] pulse.
REQ-036 Channels 0..3 reach WAIT together -> DRAIN order 0,1,2,3; never two ve bits high; motor=1 throughout each DRAIN.
REQ-037 start dropped during PROC of ch2 -> ch2 goes to WAIT next cycle, then drains normally.
REQ-038 nivel_alto[1]=nivel_baixo[1]=1 during FILL -> ch1 ALARM next cycle, ev1=0.
REQ-039 reset_n asserted mid-DRAIN -> ve, motor, estado go 0 before the next clock edge.

Source files
------------

// File: rtl/mef_tanques_pkg.sv
// Shared state codes, default timing constants and sizing helper for the tank controller.
package mef_tanques_pkg;

  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PROC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ALARM = 3'd5
  } state_t;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_TW          = 8;
  localparam int unsigned DEF_T_FILL_MAX  = 200;
  localparam int unsigned DEF_T_PROC      = 50;
  localparam int unsigned DEF_T_DRAIN_MAX = 200;

  // Width of a channel index; never below one bit so a single-channel build still has a pointer.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mef_canal.sv
// One tank channel: fill / process / wait-for-pump / drain / alarm sequence with its own timer.
module mef_canal
  import mef_tanques_pkg::*;
#(
  parameter int unsigned TW          = DEF_TW,
  parameter int unsigned T_FILL_MAX  = DEF_T_FILL_MAX,
  parameter int unsigned T_PROC      = DEF_T_PROC,
  parameter int unsigned T_DRAIN_MAX = DEF_T_DRAIN_MAX
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_start,
  input  logic   i_nivel_alto,
  input  logic   i_nivel_baixo,
  input  logic   i_ack,
  input  logic   i_grant,
  output logic   o_ev,
  output logic   o_ve,
  output logic   o_alarme,
  output state_t o_estado
);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          r_ev;
  logic          r_ve;
  logic          r_alarme;
  logic          w_fault;
  logic          w_fill_to;
  logic          w_proc_to;
  logic          w_drain_to;

  assign w_fault    = i_nivel_alto & i_nivel_baixo;
  assign w_fill_to  = (r_timer == TW'(T_FILL_MAX - 1));
  assign w_proc_to  = (r_timer == TW'(T_PROC - 1));
  assign w_drain_to = (r_timer == TW'(T_DRAIN_MAX - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; a both-sensors-high fault pre-empts every active-state transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_FILL;
      ST_FILL: begin
        if      (w_fault)      w_next = ST_ALARM;
        else if (i_nivel_alto) w_next = ST_PROC;
        else if (w_fill_to)    w_next = ST_ALARM;
        else if (!i_start)     w_next = ST_WAIT;
      end
      ST_PROC: begin
        if      (w_fault)                w_next = ST_ALARM;
        else if (w_proc_to || !i_start)  w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if      (w_fault) w_next = ST_ALARM;
        else if (i_grant) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if      (w_fault)       w_next = ST_ALARM;
        else if (i_nivel_baixo) w_next = ST_IDLE;
        else if (w_drain_to)    w_next = ST_ALARM;
      end
      ST_ALARM: if (i_ack) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Time-in-state counter: zero on entry, saturating count while the state holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    r_timer <= '0;
    else if (w_next != r_state)      r_timer <= '0;
    else if (r_timer != {TW{1'b1}})  r_timer <= r_timer + TW'(1);
  end

  // Valve/alarm flops track the state being entered so they line up with the state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ev     <= 1'b0;
      r_ve     <= 1'b0;
      r_alarme <= 1'b0;
    end else begin
      r_ev     <= (w_next == ST_FILL);
      r_ve     <= (w_next == ST_DRAIN);
      r_alarme <= (w_next == ST_ALARM);
    end
  end

  assign o_ev     = r_ev;
  assign o_ve     = r_ve;
  assign o_alarme = r_alarme;
  assign o_estado = r_state;

endmodule

// File: rtl/mef_tanques.sv
// Multi-tank controller: N_CH channel FSMs sharing one drain pump via a round-robin arbiter.
module mef_tanques
  import mef_tanques_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned TW          = DEF_TW,
  parameter int unsigned T_FILL_MAX  = DEF_T_FILL_MAX,
  parameter int unsigned T_PROC      = DEF_T_PROC,
  parameter int unsigned T_DRAIN_MAX = DEF_T_DRAIN_MAX
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_CH-1:0]    nivel_alto,
  input  logic [N_CH-1:0]    nivel_baixo,
  input  logic [N_CH-1:0]    ack_alarme,
  output logic [N_CH-1:0]    ev,
  output logic [N_CH-1:0]    ve,
  output logic               motor,
  output logic [N_CH-1:0]    alarme,
  output logic [SW*N_CH-1:0] estado
);

  localparam int unsigned PW = idx_w(N_CH);

  state_t          w_state [N_CH];
  logic [N_CH-1:0] w_wait;
  logic [N_CH-1:0] w_drain;
  logic [N_CH-1:0] w_grant;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_winner;
  logic            w_found;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mef_canal #(
      .TW          (TW),
      .T_FILL_MAX  (T_FILL_MAX),
      .T_PROC      (T_PROC),
      .T_DRAIN_MAX (T_DRAIN_MAX)
    ) u_canal (
      .clock         (clock),
      .reset_n       (reset_n),
      .i_start       (start),
      .i_nivel_alto  (nivel_alto[gi]),
      .i_nivel_baixo (nivel_baixo[gi]),
      .i_ack         (ack_alarme[gi]),
      .i_grant       (w_grant[gi]),
      .o_ev          (ev[gi]),
      .o_ve          (ve[gi]),
      .o_alarme      (alarme[gi]),
      .o_estado      (w_state[gi])
    );

    assign estado[SW*gi +: SW] = w_state[gi];
    assign w_wait[gi]          = (w_state[gi] == ST_WAIT);
    assign w_drain[gi]         = (w_state[gi] == ST_DRAIN);
  end

  assign motor = |ve;

  // Round-robin pick: first waiting channel at or after the pointer, only while the pump is free
  always_comb begin
    w_grant  = '0;
    w_found  = 1'b0;
    w_winner = '0;
    if (!(|w_drain)) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!w_found && w_wait[PW'((32'(r_ptr) + k) % N_CH)]) begin
          w_found  = 1'b1;
          w_winner = PW'((32'(r_ptr) + k) % N_CH);
        end
      end
      if (w_found) w_grant[w_winner] = 1'b1;
    end
  end

  // Pointer moves just past the last winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_ptr <= '0;
    else if (w_found) r_ptr <= (w_winner == PW'(N_CH - 1)) ? '0 : w_winner + PW'(1);
  end

endmodule

// File: tb/tb_mef_tanques.sv
// Self-checking bench for mef_tanques: directed scenarios plus randomized run against a cycle model.
module tb_mef_tanques;

  localparam int N   = 4;
  localparam int TFM = 10;
  localparam int TP  = 5;
  localparam int TDM = 10;

  localparam int IDLE  = 0;
  localparam int FILL  = 1;
  localparam int PROC  = 2;
  localparam int WAIT  = 3;
  localparam int DRAIN = 4;
  localparam int ALARM = 5;

  logic           clock       = 1'b0;
  logic           reset_n     = 1'b0;
  logic           start       = 1'b0;
  logic [N-1:0]   nivel_alto  = '0;
  logic [N-1:0]   nivel_baixo = '0;
  logic [N-1:0]   ack_alarme  = '0;
  logic [N-1:0]   ev;
  logic [N-1:0]   ve;
  logic           motor;
  logic [N-1:0]   alarme;
  logic [3*N-1:0] estado;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: phase per channel, cycles spent in it, pump pointer
  int m_ph  [N];
  int m_age [N];
  int m_ptr;

  int             ev0_cnt;
  int             motor_cnt;
  int             drain_order [$];
  logic [3*N-1:0] prev_estado = '0;

  mef_tanques #(
    .N_CH        (N),
    .TW          (8),
    .T_FILL_MAX  (TFM),
    .T_PROC      (TP),
    .T_DRAIN_MAX (TDM)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .nivel_alto  (nivel_alto),
    .nivel_baixo (nivel_baixo),
    .ack_alarme  (ack_alarme),
    .ev          (ev),
    .ve          (ve),
    .motor       (motor),
    .alarme      (alarme),
    .estado      (estado)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i]  = IDLE;
      m_age[i] = 0;
    end
    m_ptr = 0;
  endtask

  // One clock of the plant rules, using the inputs that will be present at the edge
  task automatic model_step();
    int nxt [N];
    int g;
    bit busy;
    bit hi;
    bit lo;
    busy = 1'b0;
    for (int i = 0; i < N; i++) if (m_ph[i] == DRAIN) busy = 1'b1;
    g = -1;
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_ph[(m_ptr + k) % N] == WAIT) g = (m_ptr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      hi = nivel_alto[i];
      lo = nivel_baixo[i];
      nxt[i] = m_ph[i];
      if (m_ph[i] >= FILL && m_ph[i] <= DRAIN && hi && lo) nxt[i] = ALARM;
      else begin
        case (m_ph[i])
          IDLE:  if (start) nxt[i] = FILL;
          FILL:  if (hi) nxt[i] = PROC;
                 else if (m_age[i] == TFM - 1) nxt[i] = ALARM;
                 else if (!start) nxt[i] = WAIT;
          PROC:  if (m_age[i] == TP - 1 || !start) nxt[i] = WAIT;
          WAIT:  if (g == i) nxt[i] = DRAIN;
          DRAIN: if (lo) nxt[i] = IDLE;
                 else if (m_age[i] == TDM - 1) nxt[i] = ALARM;
          ALARM: if (ack_alarme[i]) nxt[i] = IDLE;
          default: nxt[i] = IDLE;
        endcase
      end
    end
    for (int i = 0; i < N; i++) begin
      if (nxt[i] != m_ph[i]) m_age[i] = 0;
      else if (m_age[i] < 255) m_age[i] = m_age[i] + 1;
      m_ph[i] = nxt[i];
    end
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model and enforce the valve invariants
  task automatic check_all();
    logic [3*N-1:0] e_est;
    logic [N-1:0]   e_ev;
    logic [N-1:0]   e_ve;
    logic [N-1:0]   e_al;
    logic           e_mo;
    for (int i = 0; i < N; i++) begin
      e_est[3*i +: 3] = 3'(m_ph[i]);
      e_ev[i] = (m_ph[i] == FILL);
      e_ve[i] = (m_ph[i] == DRAIN);
      e_al[i] = (m_ph[i] == ALARM);
    end
    e_mo = |e_ve;
    vectors++;
    assert ({estado, ev, ve, alarme, motor} === {e_est, e_ev, e_ve, e_al, e_mo}) else begin
      miscompares++;
      $error("FAIL outputs t=%0t: observed estado=%h ev=%b ve=%b alarme=%b motor=%b expected estado=%h ev=%b ve=%b alarme=%b motor=%b",
             $time, estado, ev, ve, alarme, motor, e_est, e_ev, e_ve, e_al, e_mo);
    end
    vectors++;
    assert (((ev & ve) == '0) && ($countones(ve) <= 1)) else begin
      miscompares++;
      $error("FAIL valve_excl t=%0t: observed ev=%b ve=%b expected disjoint, at most one ve", $time, ev, ve);
    end
    for (int i = 0; i < N; i++) begin
      if (estado[3*i +: 3] == 3'd4 && prev_estado[3*i +: 3] != 3'd4) drain_order.push_back(i);
    end
    prev_estado = estado;
    ev0_cnt     = ev0_cnt + int'(ev[0]);
    motor_cnt   = motor_cnt + int'(motor);
  endtask

  task automatic tick();
    if (reset_n) model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Let draining channels report empty on their third DRAIN cycle
  task automatic drain_run(input int n);
    repeat (n) begin
      for (int i = 0; i < N; i++) nivel_baixo[i] = (m_ph[i] == DRAIN && m_age[i] == 2);
      tick();
    end
    nivel_baixo = '0;
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, 32'(drain_order.size()), 32'd4);
    for (int i = 0; i < drain_order.size() && i < N; i++)
      check({tag, "_slot"}, 32'(drain_order[i]), 32'(i));
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] k;

    model_reset();
    ev0_cnt   = 0;
    motor_cnt = 0;

    // reset state
    tick();
    tick();
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_outs", 32'({ev, ve, alarme, motor}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // full cycle on every channel, all reaching WAIT together
    ev0_cnt   = 0;
    motor_cnt = 0;
    drain_order.delete();
    start = 1'b1;
    repeat (4) tick();
    nivel_alto = '1;
    tick();
    nivel_alto = '0;
    check("ch0_proc", 32'(estado[2:0]), 32'd2);
    repeat (5) tick();
    check("all_wait", 32'(estado), 32'h6DB);
    start = 1'b0;
    drain_run(30);
    check("ev0_cycles", 32'(ev0_cnt), 32'd4);
    check("motor_cycles", 32'(motor_cnt), 32'd12);
    check_order("rr_order");
    check("idle_after_drain", 32'(estado), 32'd0);

    // fill timeout into alarm, held until acknowledged
    start = 1'b1;
    repeat (10) tick();
    check("no_alarm_at_9", 32'(alarme), 32'h0);
    tick();
    check("alarm_at_10", 32'(alarme), 32'hF);
    start = 1'b0;
    repeat (3) tick();
    check("alarm_held", 32'(alarme), 32'hF);
    ack_alarme = 4'b0001;
    tick();
    ack_alarme = '0;
    check("ack_ch0", 32'(alarme), 32'hE);
    ack_alarme = 4'b1110;
    tick();
    ack_alarme = '0;
    check("ack_rest", 32'(alarme), 32'h0);

    // start dropped during PROC
    drain_order.delete();
    start = 1'b1;
    tick();
    nivel_alto = '1;
    tick();
    nivel_alto = '0;
    tick();
    start = 1'b0;
    tick();
    check("ch2_wait", 32'(estado[8:6]), 32'd3);
    drain_run(30);
    check_order("rr_order2");

    // sensor fault during FILL on channel 1
    start = 1'b1;
    tick();
    nivel_alto[1]  = 1'b1;
    nivel_baixo[1] = 1'b1;
    tick();
    check("ch1_fault_state", 32'(estado[5:3]), 32'd5);
    check("ch1_fault_ev", 32'(ev[1]), 32'd0);
    nivel_alto  = '0;
    nivel_baixo = '0;
    start       = 1'b0;
    tick();
    drain_run(30);
    ack_alarme = 4'b0010;
    tick();
    ack_alarme = '0;
    check("all_idle_after_fault", 32'(estado), 32'd0);

    // asynchronous reset while draining
    start = 1'b1;
    tick();
    nivel_alto = '1;
    tick();
    nivel_alto = '0;
    start      = 1'b0;
    tick();
    tick();
    check("pre_reset_drain", 32'($countones(ve)), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ve", 32'(ve), 32'd0);
    check("async_motor", 32'(motor), 32'd0);
    check("async_estado", 32'(estado), 32'd0);
    check("async_ev_alarme", 32'({ev, alarme}), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // randomized traffic
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        a[i] = (m_ph[i] == FILL)  && ($urandom_range(0, 5) == 0);
        b[i] = (m_ph[i] == DRAIN) && ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 59) == 0) begin
          a[i] = 1'b1;
          b[i] = 1'b1;
        end
        k[i] = (m_ph[i] == ALARM) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      end
      nivel_alto  = a;
      nivel_baixo = b;
      ack_alarme  = k;
      start       = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
